// File: rtl/plot_clip_buffer.sv
// Clips off-screen plot requests, drops repeated pixels and buffers the rest
// for a backpressured framebuffer write port; done only once fully drained.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, in_done             job control (level start, upstream finished)
//   in_valid/in_ready          pixel request handshake (in_x, in_y, in_colour)
//   out_valid/out_ready        FIFO head handshake (out_x, out_y, out_colour)
//   done                       job complete and FIFO empty
//   plot_count, clip_count     per-job saturating counters
module plot_clip_buffer #(
  parameter int DEPTH = 8,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120,
  parameter bit DEDUP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        done,
  output logic [15:0] plot_count,
  output logic [15:0] clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] XM = 9'(X_MAX);
  localparam logic [7:0] YM = 8'(Y_MAX);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  pix_t        mem [DEPTH];
  pix_t        in_pix;
  pix_t        head;
  pix_t        last;
  logic        last_v;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        accept;
  logic        clip;
  logic        dup;
  logic        push;
  logic        pop;

  assign in_pix = '{x: in_x, y: in_y, c: in_colour};

  // Extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = (state == ACTIVE) && !full;
  assign accept   = in_valid && in_ready;

  assign clip = ({1'b0, in_x} >= XM) || ({1'b0, in_y} >= YM);
  assign dup  = DEDUP && last_v && (in_pix == last);
  assign push = accept && !clip && !dup;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Head is gated so the outputs read zero whenever nothing is buffered.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_x      = empty ? '0 : head.x;
  assign out_y      = empty ? '0 : head.y;
  assign out_colour = empty ? '0 : head.c;

  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      plot_count <= '0;
      clip_count <= '0;
      last       <= '0;
      last_v     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ACTIVE;
            plot_count <= '0;
            clip_count <= '0;
            last_v     <= 1'b0;
          end
        end
        ACTIVE: begin
          if (in_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept && clip && clip_count != 16'hFFFF) begin
        clip_count <= clip_count + 16'd1;
      end
      if (push) begin
        last   <= in_pix;
        last_v <= 1'b1;
        if (plot_count != 16'hFFFF) begin
          plot_count <= plot_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_plot_clip_buffer.sv
// Scoreboard bench for plot_clip_buffer: directed job scenarios plus
// randomized traffic checked against a rule-level reference model.
module tb_plot_clip_buffer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_done = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [6:0]  in_y = '0;
  logic [2:0]  in_colour = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        done;
  logic [15:0] plot_count;
  logic [15:0] clip_count;

  logic        d1_start = 1'b0;
  logic        d1_in_done = 1'b0;
  logic        d1_in_valid = 1'b0;
  logic        d1_in_ready;
  logic [7:0]  d1_in_x = '0;
  logic [6:0]  d1_in_y = '0;
  logic [2:0]  d1_in_colour = '0;
  logic        d1_out_valid;
  logic        d1_out_ready = 1'b0;
  logic [7:0]  d1_out_x;
  logic [6:0]  d1_out_y;
  logic [2:0]  d1_out_colour;
  logic        d1_done;
  logic [15:0] d1_plot;
  logic [15:0] d1_clip;

  int   errors = 0;
  int   checks = 0;
  int   rmode = 0;
  int   pops = 0;
  int   d1_pops = 0;
  pix_t exp_q[$];
  pix_t m_last;
  bit   m_last_v = 0;
  int   m_plot = 0;
  int   m_clip = 0;
  bit   hold_v = 0;
  pix_t held;

  always #5 clk = ~clk;

  plot_clip_buffer #(.DEPTH(8), .X_MAX(160), .Y_MAX(120), .DEDUP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_done(in_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .done(done),
    .plot_count(plot_count), .clip_count(clip_count)
  );

  plot_clip_buffer #(.DEPTH(8), .X_MAX(160), .Y_MAX(120), .DEDUP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(d1_start), .in_done(d1_in_done),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_x(d1_in_x),
    .in_y(d1_in_y), .in_colour(d1_in_colour), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .out_x(d1_out_x), .out_y(d1_out_y),
    .out_colour(d1_out_colour), .done(d1_done), .plot_count(d1_plot),
    .clip_count(d1_clip)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    pix_t p;
    pix_t e;
    if (rst_n) begin
      p = '{x: out_x, y: out_y, c: out_colour};
      if (hold_v) begin
        chk("head_hold_valid", 32'(out_valid), 32'd1);
        chk("head_hold_data", 32'(p), 32'(held));
      end
      hold_v = 0;
      if (out_valid) begin
        if (out_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_pix", 32'(p), 32'(e));
          end
        end else begin
          hold_v = 1;
          held = p;
        end
      end
      if (in_valid && in_ready) begin
        p = '{x: in_x, y: in_y, c: in_colour};
        if (in_x >= 8'd160 || in_y >= 7'd120) begin
          m_clip++;
        end else if (!(m_last_v && p == m_last)) begin
          exp_q.push_back(p);
          m_plot++;
          m_last = p;
          m_last_v = 1;
        end
      end
      if (d1_out_valid && d1_out_ready) d1_pops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c);
    int n = 0;
    in_x = x;
    in_y = y;
    in_colour = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_job();
    int n = 0;
    start = 1'b1;
    m_plot = 0;
    m_clip = 0;
    m_last_v = 0;
    tick();
    while (!in_ready && n < 20) begin
      n++;
      tick();
    end
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_plot_clr", 32'(plot_count), 32'd0);
    chk("start_clip_clr", 32'(clip_count), 32'd0);
  endtask

  task automatic end_job(input int ep, input int ec);
    int n = 0;
    if (rmode == 0) rmode = 1;
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    chk("drain_ready", 32'(in_ready), 32'd0);
    while (!done && n < 400) begin
      n++;
      tick();
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("job_plot", 32'(plot_count), 32'(ep));
    chk("job_clip", 32'(clip_count), 32'(ec));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    start = 1'b0;
    tick();
    chk("done_fall", 32'(done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    pix_t rp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", 32'({out_x, out_y, out_colour}), 32'd0);
    chk("rst_counts", 32'({plot_count, clip_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: basic order and one-cycle latency
    rmode = 1;
    start_job();
    in_x = 8'd10;
    in_y = 7'd20;
    in_colour = 3'd5;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(in_ready), 32'd1);
    chk("t1_empty_before", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t1_latency", 32'(out_valid), 32'd1);
    push(8'd159, 7'd119, 3'd1);
    end_job(2, 0);

    // 2: clipping
    start_job();
    push(8'd160, 7'd0, 3'd2);
    push(8'd0, 7'd120, 3'd3);
    push(8'd255, 7'd127, 3'd7);
    push(8'd5, 7'd5, 3'd4);
    end_job(1, 3);

    // 3: dedup on, then dedup off
    p0 = pops;
    start_job();
    repeat (3) push(8'd30, 7'd40, 3'd6);
    push(8'd30, 7'd40, 3'd2);
    end_job(2, 0);
    chk("t3_pops", 32'(pops - p0), 32'd2);
    d1_out_ready = 1'b1;
    d1_start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      d1_in_x = 8'd30;
      d1_in_y = 7'd40;
      d1_in_colour = (i == 3) ? 3'd2 : 3'd6;
      d1_in_valid = 1'b1;
      @(negedge clk);
      chk("t3_d1_ready", 32'(d1_in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    d1_in_valid = 1'b0;
    repeat (4) tick();
    chk("t3_d1_pops", 32'(d1_pops), 32'd4);
    chk("t3_d1_plot", 32'(d1_plot), 32'd4);

    // 4: fill, backpressure, wrap
    rmode = 0;
    start_job();
    fork
      for (int i = 0; i < 10; i++)
        push(8'(i * 3 + 1), 7'(i + 2), 3'(i));
      begin
        repeat (20) tick();
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        chk("t4_plot8", 32'(plot_count), 32'd8);
        chk("t4_head", 32'({out_x, out_y, out_colour}),
            32'({8'd1, 7'd2, 3'd0}));
        rmode = 1;
      end
    join
    end_job(10, 0);

    // 5: drain then done timing
    rmode = 0;
    start_job();
    for (int i = 0; i < 5; i++) push(8'(50 + i), 7'(60), 3'd3);
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    chk("t5_ready_low", 32'(in_ready), 32'd0);
    chk("t5_done_low", 32'(done), 32'd0);
    rmode = 1;
    n = 0;
    @(negedge clk);
    while (out_valid && n < 50) begin
      if (done) chk("t5_done_early", 32'(done), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("t5_empty_done0", 32'(done), 32'd0);
    @(negedge clk);
    chk("t5_done1", 32'(done), 32'd1);
    chk("t5_plot", 32'(plot_count), 32'd5);
    @(posedge clk);
    #1;
    start = 1'b0;
    tick();
    chk("t5_done_fall", 32'(done), 32'd0);
    chk("t5_idle_ready", 32'(in_ready), 32'd0);
    chk("t5_hold_plot", 32'(plot_count), 32'd5);

    // random traffic
    rmode = 2;
    start_job();
    rp = '0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rp.x = 8'($urandom_range(0, 200));
        rp.y = 7'($urandom_range(0, 127));
        rp.c = 3'($urandom);
      end
      push(rp.x, rp.y, rp.c);
      if ($urandom_range(0, 3) == 0) tick();
    end
    end_job(m_plot, m_clip);

    // 6: async reset mid-job
    rmode = 0;
    start_job();
    for (int i = 0; i < 4; i++) push(8'(70 + i), 7'(i), 3'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    chk("t6_counts", 32'({plot_count, clip_count}), 32'd0);
    exp_q.delete();
    hold_v = 0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rmode = 1;
    start_job();
    chk("t6_empty", 32'(out_valid), 32'd0);
    push(8'd1, 7'd1, 3'd1);
    push(8'd2, 7'd2, 3'd2);
    end_job(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plot_clip_buffer.md
Name: plot_clip_buffer

Overview:
- Sits directly downstream of the circle drawer, between its pixel output and the framebuffer/VGA adapter write port.
- Accepts pixel plot requests (x, y, colour) through a valid/ready handshake and discards off-screen pixels (x ≥ 160 or y ≥ 120).
- Optionally suppresses back-to-back duplicate pixels, produced by octant overlap on the axes and diagonals.
- Buffers surviving pixels in a small FIFO drained by a backpressured write port, and signals drawing completion only after the buffer has fully drained.

Parameters:
DEPTH  8  FIFO entries; power of two, ≥ 2
X_MAX  160  first illegal x coordinate
Y_MAX  120  first illegal y coordinate
DEDUP  1  1 = drop a pixel identical to the last pushed pixel; 0 = disabled

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; high begins a drawing job, held high until done is seen
in_done  in  1  upstream drawer finished issuing pixels (level or pulse)
in_valid  in  1  pixel request valid
in_ready  out  1  block accepts the pixel this cycle
in_x  in  8  pixel x
in_y  in  7  pixel y
in_colour  in  3  pixel colour
out_valid  out  1  FIFO head valid
out_ready  in  1  sink accepts the head this cycle
out_x  out  8  head x
out_y  out  7  head y
out_colour  out  3  head colour
done  out  1  job complete and FIFO empty
plot_count  out  16  pixels pushed this job, saturating at 16'hFFFF
clip_count  out  16  pixels discarded by clipping this job, saturating

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; FIFO empty with pointers 0.
  - in_ready, out_valid and done are 0; out_x, out_y and out_colour are 0.
  - Both counters 0; dedup "last" register invalid.
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE: in_ready = 0. When start = 1, move to ACTIVE next cycle, clear counters and invalidate "last".
  - ACTIVE: in_ready = !full. When in_done = 1, move to DRAIN. A pixel handshaken in the same cycle as in_done is still processed.
  - DRAIN: in_ready = 0. When FIFO is empty and no pop is in flight, move to DONE.
  - DONE: done = 1. When start = 0, move to IDLE; done falls in the same cycle the state leaves DONE.
- Accept: a pixel is accepted on any cycle with in_valid & in_ready. Each accepted pixel is classified in this priority order:
  - Clipped when in_x ≥ X_MAX or in_y ≥ Y_MAX. clip_count increments; nothing is pushed.
  - Duplicate (only when DEDUP = 1) when "last" is valid and {x, y, colour} equals "last". Dropped; no counter change.
  - Otherwise pushed into the FIFO. plot_count increments and "last" is updated.
- FIFO behaviour:
  - First-word-fall-through.
  - out_valid = !empty.
  - Head data stays stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
  - Latency from accept to out_valid is exactly 1 cycle when the FIFO is empty (no combinational bypass).
- FIFO boundary conditions:
  - Simultaneous push and pop when not full: occupancy unchanged.
  - When full, in_ready = 0 even if the pending pixel would be clipped.
  - Pointers are log2(DEPTH) + 1 bits; full/empty come from MSB compare, so wrap-around requires no special case.
- Counters saturate at 16'hFFFF and never wrap. They hold their value through DONE and IDLE and clear only on entry to ACTIVE.
- out_* keep draining in every state. A pixel accepted in ACTIVE is always delivered, even after the state has advanced to DRAIN.
- start falling in ACTIVE or DRAIN: ignored; the job completes normally. done then pulses for one cycle (DONE sees start = 0 and exits).
- Reset mid-job: everything returns immediately to reset values. Buffered pixels are lost.

Test Plan:
1. Reset, start = 1, push (10,20,c5), (159,119,c1), out_ready = 1 → two outputs in order; the first has out_valid 1 cycle after accept; plot_count = 2, clip_count = 0.
2. Push (160,0,c2), (0,120,c3), (255,127,c7), (5,5,c4) → only (5,5,c4) emerges; clip_count = 3, plot_count = 1.
3. DEDUP = 1: push (30,40,c6) three times, then (30,40,c2) → exactly 2 outputs; plot_count = 2. With DEDUP = 0 → 4 outputs.
4. out_ready = 0, push 10 valid pixels, DEPTH = 8 → in_ready drops after the 8th accept and head data stays stable. Raise out_ready → all 8 drain in order, then pixels 9 and 10 are accepted and drained in order (pointer wrap exercised).
5. With 5 entries buffered, pulse in_done → in_ready = 0 immediately; done = 0 until the 5th pop, done = 1 one cycle after the FIFO empties. Drop start → done = 0 and state IDLE next cycle; a new start clears both counters.
6. Assert rst_n low with 4 entries buffered in ACTIVE → out_valid, done, counters and in_ready go to 0 asynchronously. After release, start = 1 resumes from an empty FIFO.
